// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, funcs, FSM states, ALU ops.
// Latency: n/a (constants and pure combinational helper functions only).
// Backpressure: n/a.
package cpu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OR  = 2'd2,
    ALU_SLT = 2'd3
  } alu_op_e;

  typedef enum logic {
    IMM_SEXT = 1'b0,
    IMM_ZEXT = 1'b1
  } imm_sel_e;

  // True for every encoding the core implements; anything else traps to HALT.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADDU) || (fn == FN_SUBU) ||
                     (fn == FN_OR)   || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDIU, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input imm_sel_e sel);
    return (sel == IMM_ZEXT) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

  // Shared ALU; no overflow detection, wraps modulo 2^32.
  function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: y = 32'd0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
`timescale 1ns/1ps
// 32x32 register file: two async read ports, one sync write port, $0 hardwired to zero.
// Latency: reads combinational; a write lands at the clock edge ending the write cycle.
// Backpressure: none; the write is accepted whenever i_we is high.
// Ports: clk/clr (async active-low, clears every entry), i_we/i_waddr/i_wdata write port,
//        i_raddr1/2 -> o_rdata1/2 read ports, o_r8/o_r16/o_r17/o_r18 debug taps.
module cpu_regfile (
  input  logic        clk,
  input  logic        clr,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  output logic [31:0] o_r8,
  output logic [31:0] o_r16,
  output logic [31:0] o_r17,
  output logic [31:0] o_r18
);

  logic [31:0] r_mem [0:31];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Entry 0 is never written, but the read mux still forces zero so the
  // invariant does not depend on the write guard alone.
  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];

  assign o_r8  = r_mem[8];
  assign o_r16 = r_mem[16];
  assign o_r17 = r_mem[17];
  assign o_r18 = r_mem[18];

endmodule

// File: rtl/multi_cycle_cpu.sv
`timescale 1ns/1ps
// Multi-cycle MIPS-subset core sharing one ALU across FETCH/EXEC; traps illegal encodings to HALT.
// Latency: 3 cycles (beq/j), 4 (R-type/addiu/ori/sw), 5 (lw) plus one per memory wait cycle.
// Backpressure: imem/dmem req held with stable addr/we/wdata until ack; req drops the cycle after.
// Ports: clk, clr (async active-low); imem_req/addr/ack/rdata fetch port;
//        dmem_req/we/addr/wdata/ack/rdata data port; halted; r8/r16/r17/r18/pc debug taps.
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int          AW       = 8,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic          clk,
  input  logic          clr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_ack,
  input  logic [31:0]   dmem_rdata,
  output logic          halted,
  output logic [31:0]   r8,
  output logic [31:0]   r16,
  output logic [31:0]   r17,
  output logic [31:0]   r18,
  output logic [31:0]   pc
);

  // Architectural / datapath registers
  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu;
  logic [31:0] r_mdr;

  // Instruction fields
  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [25:0] w_adr;

  assign w_op  = r_ir[31:26];
  assign w_rs  = r_ir[25:21];
  assign w_rt  = r_ir[20:16];
  assign w_rd  = r_ir[15:11];
  assign w_fn  = r_ir[5:0];
  assign w_imm = r_ir[15:0];
  assign w_adr = r_ir[25:0];

  // Decode
  imm_sel_e    w_imm_sel;
  logic [31:0] w_imm_ext;
  alu_op_e     w_exec_op;
  logic        w_use_imm;
  logic        w_legal;

  assign w_imm_sel = (w_op == OP_ORI) ? IMM_ZEXT : IMM_SEXT;
  assign w_imm_ext = ext_imm(w_imm, w_imm_sel);
  assign w_use_imm = (w_op != OP_RTYPE);
  assign w_legal   = is_legal(w_op, w_fn);

  always_comb begin
    w_exec_op = ALU_ADD;
    if (w_op == OP_RTYPE) begin
      case (w_fn)
        FN_SUBU: w_exec_op = ALU_SUB;
        FN_OR:   w_exec_op = ALU_OR;
        FN_SLT:  w_exec_op = ALU_SLT;
        default: w_exec_op = ALU_ADD;
      endcase
    end else if (w_op == OP_ORI) begin
      w_exec_op = ALU_OR;
    end
  end

  // Shared ALU operand steering: FETCH uses it for pc+4, EXEC of beq for the
  // branch target (relative to the already-incremented pc), otherwise it
  // computes the instruction result or the lw/sw effective address.
  alu_op_e     w_alu_op;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_y;

  always_comb begin
    w_alu_op = ALU_ADD;
    w_alu_a  = r_a;
    w_alu_b  = w_use_imm ? w_imm_ext : r_b;
    if (r_state == ST_FETCH) begin
      w_alu_a = r_pc;
      w_alu_b = 32'd4;
    end else if (w_op == OP_BEQ) begin
      w_alu_a = r_pc;
      w_alu_b = {w_imm_ext[29:0], 2'b00};
    end else begin
      w_alu_op = w_exec_op;
    end
  end

  assign w_alu_y = alu_calc(w_alu_op, w_alu_a, w_alu_b);

  logic        w_br_taken;
  logic [31:0] w_jmp_tgt;

  // The branch compare gets its own comparator because the ALU is busy
  // producing the target in the same cycle.
  assign w_br_taken = (r_a == r_b);
  assign w_jmp_tgt  = {r_pc[31:28], w_adr, 2'b00};

  // Register file
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic [31:0] w_rf_rd1;
  logic [31:0] w_rf_rd2;

  assign w_rf_we    = (r_state == ST_WB);
  assign w_rf_waddr = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_rf_wdata = (w_op == OP_LW) ? r_mdr : r_alu;

  cpu_regfile u_regfile (
    .clk      (clk),
    .clr      (clr),
    .i_we     (w_rf_we),
    .i_waddr  (w_rf_waddr),
    .i_wdata  (w_rf_wdata),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rf_rd1),
    .o_rdata2 (w_rf_rd2),
    .o_r8     (r8),
    .o_r16    (r16),
    .o_r17    (r17),
    .o_r18    (r18)
  );

  // Control FSM
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_START;
      r_pc    <= PC_RESET;
      r_ir    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_alu   <= 32'd0;
      r_mdr   <= 32'd0;
    end else begin
      case (r_state)
        ST_START: r_state <= ST_FETCH;

        ST_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_pc    <= w_alu_y;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          r_a     <= w_rf_rd1;
          r_b     <= w_rf_rd2;
          r_state <= w_legal ? ST_EXEC : ST_HALT;
        end

        ST_EXEC: begin
          r_alu <= w_alu_y;
          case (w_op)
            OP_BEQ: begin
              if (w_br_taken) begin
                r_pc <= w_alu_y;
              end
              r_state <= ST_FETCH;
            end
            OP_J: begin
              r_pc    <= w_jmp_tgt;
              r_state <= ST_FETCH;
            end
            OP_LW, OP_SW: r_state <= ST_MEM;
            default:      r_state <= ST_WB;
          endcase
        end

        ST_MEM: begin
          if (dmem_ack) begin
            if (w_op == OP_LW) begin
              r_mdr   <= dmem_rdata;
              r_state <= ST_WB;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end

        ST_WB:   r_state <= ST_FETCH;

        ST_HALT: r_state <= ST_HALT;

        default: r_state <= ST_HALT;
      endcase
    end
  end

  // Memory-side outputs come only from state and latched registers, so an
  // ack can never combinationally feed back into req.
  assign imem_req   = (r_state == ST_FETCH);
  assign imem_addr  = r_pc[AW-1:0];
  assign dmem_req   = (r_state == ST_MEM);
  assign dmem_we    = dmem_req && (w_op == OP_SW);
  assign dmem_addr  = r_alu[AW-1:0];
  assign dmem_wdata = r_b;
  assign halted     = (r_state == ST_HALT);
  assign pc         = r_pc;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
`timescale 1ns/1ps
// Directed bench for multi_cycle_cpu: zero-wait imem, programmable-delay dmem.
// Latency: each check is placed at a hand-counted clock edge after reset release.
// Backpressure: dmem_ack is delayed by dly cycles from the first req cycle.
module tb_multi_cycle_cpu;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          dmem_ack;
  logic [31:0]   dmem_rdata;
  logic          halted;
  logic [31:0]   r8, r16, r17, r18, pc;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  int          dly = 0;
  int          dcnt = 0;
  logic        mem_wipe = 1'b0;
  logic        force_ack = 1'b0;
  int          edge_n = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          busy;

  multi_cycle_cpu #(.AW(AW), .PC_RESET(32'h0)) dut (
    .clk        (clk),
    .clr        (clr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .r8         (r8),
    .r16        (r16),
    .r17        (r17),
    .r18        (r18),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  // Memory models
  assign imem_ack   = imem_req || force_ack;
  assign imem_rdata = imem[imem_addr[AW-1:2]];
  assign dmem_ack   = (dmem_req && (dcnt == dly)) || force_ack;
  assign dmem_rdata = dmem[dmem_addr[AW-1:2]];

  always @(posedge clk) begin
    if (mem_wipe) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
    end else if (dmem_req && dmem_we && dmem_ack) begin
      dmem[dmem_addr[AW-1:2]] <= dmem_wdata;
    end
    if (!dmem_req || dmem_ack) dcnt <= 0;
    else                       dcnt <= dcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance to absolute edge e (counted from reset release), then sample 1ns later.
  task automatic run_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic hold_reset();
    clr      = 1'b0;
    mem_wipe = 1'b1;
    @(posedge clk);
    #1;
    mem_wipe = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    clr    = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    #2;
    // ---- reset state
    hold_reset();
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_dmem_we",  {31'd0, dmem_we},  32'd0);
    check("rst_halted",   {31'd0, halted},   32'd0);
    check("rst_pc",       pc,  32'h0);
    check("rst_r17",      r17, 32'h0);

    // ---- T1: ori/ori/addu/subu, zero-wait; then word 0 (sll) traps
    imem[0] = 32'h34080005;  // ori  $8,$0,5
    imem[1] = 32'h34100007;  // ori  $16,$0,7
    imem[2] = 32'h01108821;  // addu $17,$8,$16
    imem[3] = 32'h01109023;  // subu $18,$8,$16
    release_reset();
    #1;
    check("t1_start_no_req", {31'd0, imem_req}, 32'd0);
    run_to(1);
    check("t1_first_req",  {31'd0, imem_req}, 32'd1);
    check("t1_first_addr", {24'd0, imem_addr}, 32'h0);
    run_to(16);
    check("t1_r18_e16", r18, 32'h0);
    run_to(17);
    check("t1_r8",  r8,  32'd5);
    check("t1_r16", r16, 32'd7);
    check("t1_r17", r17, 32'd12);
    check("t1_r18", r18, 32'hFFFFFFFE);
    check("t1_pc",  pc,  32'h10);
    run_to(19);
    check("t1_sll_halt", {31'd0, halted}, 32'd1);
    check("t1_sll_pc",   pc, 32'h14);

    // ---- T2: sw/lw with 3-cycle dmem wait
    hold_reset();
    dly     = 3;
    imem[0] = 32'h3411000C;  // ori $17,$0,12
    imem[1] = 32'hAC110004;  // sw  $17,4($0)
    imem[2] = 32'h8C120004;  // lw  $18,4($0)
    release_reset();
    run_to(8);
    check("t2_sw_req",   {31'd0, dmem_req}, 32'd1);
    check("t2_sw_we",    {31'd0, dmem_we},  32'd1);
    check("t2_sw_addr",  {24'd0, dmem_addr}, 32'h4);
    check("t2_sw_wdata", dmem_wdata, 32'd12);
    run_to(11);
    check("t2_sw_req_c4",  {31'd0, dmem_req}, 32'd1);
    check("t2_sw_addr_c4", {24'd0, dmem_addr}, 32'h4);
    run_to(12);
    check("t2_sw_req_drop", {31'd0, dmem_req}, 32'd0);
    check("t2_sw_stored",   dmem[1], 32'd12);
    run_to(15);
    check("t2_lw_req",  {31'd0, dmem_req}, 32'd1);
    check("t2_lw_we",   {31'd0, dmem_we},  32'd0);
    check("t2_lw_addr", {24'd0, dmem_addr}, 32'h4);
    run_to(18);
    check("t2_lw_req_c4", {31'd0, dmem_req}, 32'd1);
    run_to(19);
    check("t2_lw_req_drop", {31'd0, dmem_req}, 32'd0);
    check("t2_r18_e19", r18, 32'd0);
    run_to(20);
    check("t2_r18", r18, 32'd12);
    check("t2_pc",  pc,  32'h0C);

    // ---- T3a: j 0x20, beq $0,$0,-2 taken
    hold_reset();
    dly     = 0;
    imem[0] = 32'h08000008;  // j 0x20
    imem[8] = 32'h1000FFFE;  // beq $0,$0,-2
    release_reset();
    run_to(4);
    check("t3_j_pc",   pc, 32'h20);
    check("t3_j_addr", {24'd0, imem_addr}, 32'h20);
    run_to(6);
    check("t3_beq_pc_inc", pc, 32'h24);
    run_to(7);
    check("t3_beq_taken", {24'd0, imem_addr}, 32'h1C);
    check("t3_beq_req",   {31'd0, imem_req}, 32'd1);

    // ---- T3b: beq not taken, then j adr 0x10
    hold_reset();
    imem[0] = 32'h34080001;  // ori $8,$0,1
    imem[1] = 32'h08000008;  // j 0x20
    imem[8] = 32'h1100FFFE;  // beq $8,$0,-2
    imem[9] = 32'h08000010;  // j adr 0x10
    release_reset();
    run_to(11);
    check("t3_beq_not_taken", pc, 32'h24);
    run_to(14);
    check("t3_j40_pc",   pc, 32'h40);
    check("t3_j40_addr", {24'd0, imem_addr}, 32'h40);

    // ---- T4: illegal opcode 0x3F
    hold_reset();
    imem[0] = 32'hFC000000;
    release_reset();
    run_to(2);
    check("t4_pre_halt", {31'd0, halted}, 32'd0);
    run_to(3);
    check("t4_halted", {31'd0, halted}, 32'd1);
    check("t4_pc",     pc, 32'h4);
    busy = 0;
    for (int i = 4; i < 16; i++) begin
      run_to(i);
      if (imem_req || dmem_req) busy++;
    end
    check("t4_no_req", busy, 32'd0);
    check("t4_pc_frozen", pc, 32'h4);
    check("t4_still_halted", {31'd0, halted}, 32'd1);

    // ---- T5: reset while a store waits for ack
    hold_reset();
    dly     = 20;
    imem[0] = 32'h3411000C;
    imem[1] = 32'hAC110004;
    release_reset();
    run_to(9);
    check("t5_pre_req", {31'd0, dmem_req}, 32'd1);
    clr = 1'b0;
    #1;
    check("t5_req_drop",  {31'd0, dmem_req}, 32'd0);
    check("t5_ireq",      {31'd0, imem_req}, 32'd0);
    check("t5_we",        {31'd0, dmem_we},  32'd0);
    check("t5_pc",        pc,  32'h0);
    check("t5_rf_clear",  r17, 32'h0);
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_ack = 1'b0;
    check("t5_ack_ignored", {31'd0, dmem_req | imem_req}, 32'd0);
    release_reset();
    #1;
    check("t5_start_no_req", {31'd0, imem_req}, 32'd0);
    run_to(1);
    check("t5_first_req", {31'd0, imem_req}, 32'd1);
    check("t5_no_store",  dmem[1], 32'd0);

    // ---- T6: writes to $0 discarded
    hold_reset();
    dly     = 0;
    imem[0] = 32'h34080003;  // ori   $8,$0,3
    imem[1] = 32'h24000009;  // addiu $0,$0,9
    imem[2] = 32'h00004021;  // addu  $8,$0,$0
    release_reset();
    run_to(5);
    check("t6_r8_pre", r8, 32'd3);
    run_to(13);
    check("t6_r8_zero", r8, 32'd0);

    // ---- T7: addiu sign-ext, signed slt, ori zero-ext, or
    hold_reset();
    imem[0] = 32'h2410FFFF;  // addiu $16,$0,-1
    imem[1] = 32'h0200882A;  // slt   $17,$16,$0
    imem[2] = 32'h34128000;  // ori   $18,$0,0x8000
    imem[3] = 32'h02324025;  // or    $8,$17,$18
    release_reset();
    run_to(17);
    check("t7_addiu", r16, 32'hFFFFFFFF);
    check("t7_slt",   r17, 32'd1);
    check("t7_ori",   r18, 32'h00008000);
    check("t7_or",    r8,  32'h00008001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
